// File: rtl/mult_shiftadd.sv
// Sequential unsigned shift-and-add multiplier built around an N-bit ripple adder.
// One partial-product step per clock; 2N-bit product after N steps, start/busy/done handshake.

module addern #(
    parameter int N = 8
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    input  logic         cin_i,
    output logic [N-1:0] s_o,
    output logic         cout_o
);
    logic [N:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s_o[i]  = x_i[i] ^ y_i[i] ^ c[i];
        assign c[i+1]  = (x_i[i] & y_i[i]) | (c[i] & (x_i[i] ^ y_i[i]));
    end

    assign cout_o = c[N];
endmodule

module mult_shiftadd #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] q
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [N-1:0]   mcand_q;
    logic [N-1:0]   acc_hi_q;
    logic [N-1:0]   acc_lo_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;
    logic [2*N-1:0] prod_q;

    logic [N-1:0]   addend_d;
    logic [N-1:0]   sum_d;
    logic           carry_d;
    logic [2*N-1:0] shifted_d;

    assign addend_d = acc_lo_q[0] ? mcand_q : '0;

    addern #(.N(N)) u_add (
        .x_i    (acc_hi_q),
        .y_i    (addend_d),
        .cin_i  (1'b0),
        .s_o    (sum_d),
        .cout_o (carry_d)
    );

    // The carry-out becomes the new MSB, so no product bit is ever lost.
    assign shifted_d = {carry_d, sum_d, acc_lo_q[N-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            prod_q   <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    acc_hi_q <= shifted_d[2*N-1:N];
                    acc_lo_q <= shifted_d[N-1:0];
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        prod_q  <= shifted_d;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; DONE lasts one cycle.
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= a;
                        acc_hi_q <= '0;
                        acc_lo_q <= b;
                        cnt_q    <= '0;
                        state_q  <= S_RUN;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = prod_q;
endmodule
